// File: rtl/spi_master_param_if.sv
// Controller-side bundle for spi_master_param: transfer request/result handshake plus SPI pins.
// The master modport is the SPI master's view; slave is the system/board view.
interface spi_master_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned SEL_W      = 2
) ();

  logic                  i_start;
  logic [SEL_W-1:0]      i_slave_select;
  logic                  i_cpol;
  logic                  i_cpha;
  logic [DATA_WIDTH-1:0] i_master_data_to_send;
  logic [DATA_WIDTH-1:0] o_master_data_received;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_sclk;
  logic [NUM_SLAVES-1:0] o_cs;
  logic                  o_mosi;
  logic                  i_miso;

  modport master (
    input  i_start,
    input  i_slave_select,
    input  i_cpol,
    input  i_cpha,
    input  i_master_data_to_send,
    output o_master_data_received,
    output o_busy,
    output o_done,
    output o_sclk,
    output o_cs,
    output o_mosi,
    input  i_miso
  );

  modport slave (
    output i_start,
    output i_slave_select,
    output i_cpol,
    output i_cpha,
    output i_master_data_to_send,
    input  o_master_data_received,
    input  o_busy,
    input  o_done,
    input  o_sclk,
    input  o_cs,
    input  o_mosi,
    output i_miso
  );

endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master with per-transfer CPOL/CPHA and a busy/done handshake.
// Bit order is LSB first; define SPI_MASTER_MSB_FIRST_EN to shift MSB first instead.
module spi_master_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned CLK_DIV    = 1
) (
  input logic                i_clk,
  input logic                i_reset,
  spi_master_param_if.master io_bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HP_W  = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST       = HP_W'(2 * DATA_WIDTH - 1);
  localparam logic [HP_W-1:0]  HP_LAST_TRAIL = HP_W'(2 * DATA_WIDTH - 2);
  localparam logic [SEL_W:0]   NUM_SEL       = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {StIdle, StSetup, StTransfer, StHold} state_e;

  state_e                r_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [HP_W-1:0]       r_hp;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;
  logic [NUM_SLAVES-1:0] r_cs;

  logic                  w_accept;
  logic                  w_div_end;
  logic                  w_tx_bit;
  logic [DATA_WIDTH-1:0] w_tx_shift;
  logic                  w_load_bit;
  logic [DATA_WIDTH-1:0] w_load_shift;
  logic [DATA_WIDTH-1:0] w_rx_shift;

`ifdef SPI_MASTER_MSB_FIRST_EN
  assign w_tx_bit     = r_tx_sh[DATA_WIDTH-1];
  assign w_tx_shift   = {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
  assign w_load_bit   = io_bus.i_master_data_to_send[DATA_WIDTH-1];
  assign w_load_shift = {io_bus.i_master_data_to_send[DATA_WIDTH-2:0], 1'b0};
  assign w_rx_shift   = {r_rx_sh[DATA_WIDTH-2:0], io_bus.i_miso};
`else
  assign w_tx_bit     = r_tx_sh[0];
  assign w_tx_shift   = {1'b0, r_tx_sh[DATA_WIDTH-1:1]};
  assign w_load_bit   = io_bus.i_master_data_to_send[0];
  assign w_load_shift = {1'b0, io_bus.i_master_data_to_send[DATA_WIDTH-1:1]};
  assign w_rx_shift   = {io_bus.i_miso, r_rx_sh[DATA_WIDTH-1:1]};
`endif

  // The done cycle is still StIdle, so r_done blocks back-to-back acceptance.
  assign w_accept  = (r_state == StIdle) && !r_done && io_bus.i_start &&
                     ({1'b0, io_bus.i_slave_select} < NUM_SEL);
  assign w_div_end = (r_div_cnt == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_div_cnt <= '0;
      r_hp      <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          r_sclk <= io_bus.i_cpol;
          if (w_accept) begin
            r_state   <= StSetup;
            r_div_cnt <= '0;
            r_hp      <= '0;
            r_rx_sh   <= '0;
            r_cpol    <= io_bus.i_cpol;
            r_cpha    <= io_bus.i_cpha;
            r_busy    <= 1'b1;
            r_cs      <= ~(NUM_SLAVES'(1) << io_bus.i_slave_select);
            if (!io_bus.i_cpha) begin
              r_mosi  <= w_load_bit;
              r_tx_sh <= w_load_shift;
            end else begin
              r_tx_sh <= io_bus.i_master_data_to_send;
            end
          end
        end

        StSetup: begin
          if (w_div_end) begin
            // First leading SCLK edge opens half-period 0.
            r_state   <= StTransfer;
            r_div_cnt <= '0;
            r_hp      <= '0;
            r_sclk    <= ~r_sclk;
            if (!r_cpha) begin
              r_rx_sh <= w_rx_shift;
            end else begin
              r_mosi  <= w_tx_bit;
              r_tx_sh <= w_tx_shift;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        StTransfer: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            if (r_hp == HP_LAST) begin
              r_state <= StHold;
              r_sclk  <= r_cpol;
            end else begin
              r_hp   <= r_hp + HP_W'(1);
              r_sclk <= ~r_sclk;
              // Odd r_hp means the next half-period is even, i.e. a leading edge.
              if (r_hp[0]) begin
                if (!r_cpha) begin
                  r_rx_sh <= w_rx_shift;
                end else begin
                  r_mosi  <= w_tx_bit;
                  r_tx_sh <= w_tx_shift;
                end
              end else begin
                if (r_cpha) begin
                  r_rx_sh <= w_rx_shift;
                end else if (r_hp != HP_LAST_TRAIL) begin
                  r_mosi  <= w_tx_bit;
                  r_tx_sh <= w_tx_shift;
                end
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        StHold: begin
          if (w_div_end) begin
            r_state   <= StIdle;
            r_div_cnt <= '0;
            r_cs      <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx_sh;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.o_master_data_received = r_rx_data;
  assign io_bus.o_busy                 = r_busy;
  assign io_bus.o_done                 = r_done;
  assign io_bus.o_sclk                 = r_sclk;
  assign io_bus.o_cs                   = r_cs;
  assign io_bus.o_mosi                 = r_mosi;

endmodule
